// File: rtl/core_v_xif_pkg.sv
// Shared CV-X-IF result type, used by the result arbiter, its interface and the
// coprocessors and CPU that connect to it.
package core_v_xif_pkg;

    localparam int unsigned XifHartidWidth = 1;
    localparam int unsigned XifIdWidth     = 4;
    localparam int unsigned XifRfwWidth    = 32;
    // Two write-enable bits so the same layout serves single and dual writeback.
    localparam int unsigned XifWeWidth     = 2;

    typedef struct packed {
        logic [XifHartidWidth-1:0] hartid;
        logic [XifIdWidth-1:0]     id;
        logic [XifRfwWidth-1:0]    data;
        logic [4:0]                rd;
        logic [XifWeWidth-1:0]     we;
        logic                      exc;
        logic [5:0]                exccode;
        logic                      dbg;
        logic                      err;
    } x_result_t;

endpackage

// File: rtl/xif_result_arbiter_if.sv
// Result-channel bundle: NUM_COPROC coprocessor result channels on one side and the
// single CPU result channel (plus source index) on the other.
interface xif_result_arbiter_if
    import core_v_xif_pkg::*;
#(
    parameter int unsigned NUM_COPROC = 2
);
    localparam int unsigned SrcW = $clog2(NUM_COPROC);

    logic [NUM_COPROC-1:0]      co_result_valid;
    logic [NUM_COPROC-1:0]      co_result_ready;
    x_result_t [NUM_COPROC-1:0] co_result;

    logic                       cpu_result_valid;
    logic                       cpu_result_ready;
    x_result_t                  cpu_result;
    logic [SrcW-1:0]            cpu_result_src;

    // Arbiter side.
    modport master (
        input  co_result_valid,
        input  co_result,
        input  cpu_result_ready,
        output co_result_ready,
        output cpu_result_valid,
        output cpu_result,
        output cpu_result_src
    );

    // Coprocessor/CPU side.
    modport slave (
        output co_result_valid,
        output co_result,
        output cpu_result_ready,
        input  co_result_ready,
        input  cpu_result_valid,
        input  cpu_result,
        input  cpu_result_src
    );

endinterface

// File: rtl/xif_rr_arbiter.sv
// Generic N-way round-robin grant. The pointer only advances (past the winner) when
// update_i reports that the current grant was actually taken.
module xif_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic            update_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IdxW'((32'(rr_q) + off) % N);
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end

        gnt_o            = '0;
        gnt_o[gnt_idx_o] = gnt_valid_o;

        rr_d = rr_q;
        if (update_i && gnt_valid_o) begin
            rr_d = (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/xif_result_arbiter.sv
// Merges NUM_COPROC CV-X-IF result channels onto the CPU result port through a
// single registered output slot, with round-robin fairness between coprocessors.
module xif_result_arbiter
    import core_v_xif_pkg::*;
#(
    parameter int unsigned NUM_COPROC     = 2,
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned X_HARTID_WIDTH = 1,
    parameter int unsigned X_RFW_WIDTH    = 32,
    parameter int unsigned X_DUALWRITE    = 0
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    xif_result_arbiter_if.master bus
);

    localparam int unsigned SrcW = $clog2(NUM_COPROC);

    // The payload layout is fixed by the shared package; refuse mismatched builds.
    if (NUM_COPROC < 2 || X_DUALWRITE > 1 || X_ID_WIDTH != XifIdWidth ||
        X_HARTID_WIDTH != XifHartidWidth || X_RFW_WIDTH != XifRfwWidth) begin : g_bad_cfg
        $error("xif_result_arbiter: parameters do not match core_v_xif_pkg");
    end

    logic            full_q, full_d;
    x_result_t       res_q, res_d;
    logic [SrcW-1:0] src_q, src_d;

    logic                  load;
    logic                  co_hs;
    logic [NUM_COPROC-1:0] gnt;
    logic [SrcW-1:0]       gnt_idx;
    logic                  gnt_valid;

    assign load  = !full_q || bus.cpu_result_ready;
    // Reset gates the handshake so no coprocessor sees ready while reset is held.
    assign co_hs = rst_ni && load && gnt_valid;

    xif_rr_arbiter #(
        .N (NUM_COPROC)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (bus.co_result_valid),
        .update_i    (co_hs),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign bus.co_result_ready = gnt & {NUM_COPROC{co_hs}};

    always_comb begin
        full_d = full_q;
        res_d  = res_q;
        src_d  = src_q;
        if (co_hs) begin
            full_d = 1'b1;
            res_d  = bus.co_result[gnt_idx];
            src_d  = gnt_idx;
        end else if (bus.cpu_result_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            res_q  <= '0;
            src_q  <= '0;
        end else begin
            full_q <= full_d;
            res_q  <= res_d;
            src_q  <= src_d;
        end
    end

    assign bus.cpu_result_valid = full_q;
    assign bus.cpu_result       = res_q;
    assign bus.cpu_result_src   = src_q;

endmodule
